// File: rtl/mem_stage_pipe.sv
// MEM stage with MEM/WB pipeline register: sized loads/stores with sign/zero extension,
// misalignment detection, configurable memory latency with an upstream stall, and branch resolution.
module mem_stage_pipe #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_mem,
  input  logic              regwrite_mem,
  input  logic              mem2reg_mem,
  input  logic              memread_mem,
  input  logic              memwrite_mem,
  input  logic              branch_mem,
  input  logic              uncondbranch_mem,
  input  logic              alu_zero_mem,
  input  logic [1:0]        size_mem,
  input  logic              sign_mem,
  input  logic [4:0]        rd_mem,
  input  logic [DATA_W-1:0] store_data_mem,
  input  logic [DATA_W-1:0] alu_out_mem,
  input  logic [DATA_W-1:0] pc_target_mem,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target,
  output logic              valid_wb,
  output logic              regwrite_wb,
  output logic              mem2reg_wb,
  output logic              misalign_wb,
  output logic [4:0]        rd_wb,
  output logic [DATA_W-1:0] alu_out_wb,
  output logic [DATA_W-1:0] read_data_wb,
  output logic              state_dbg,
  output logic [3:0]        cnt_dbg
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam bit LAT0  = (MEM_LATENCY == 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [OFF_W-1:0]  offset;
  logic [IDX_W-1:0]  word_idx;
  logic [3:0]        size_bytes;
  logic [7:0]        lane8;
  logic [NB-1:0]     be;
  logic              size_ok;
  logic              aligned;
  logic              access;
  logic              mem_op;
  logic              misalign;
  logic              complete;
  logic              mem_we;
  logic [DATA_W-1:0] wdata_shift;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] data_mask;
  logic              sign_bit;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] read_data_next;

  assign pc_src    = valid_mem & (uncondbranch_mem | (branch_mem & alu_zero_mem));
  assign pc_target = pc_target_mem;

  // Byte offset within the word, then word index; upper address bits wrap modulo DEPTH.
  assign offset   = alu_out_mem[OFF_W-1:0];
  assign word_idx = alu_out_mem[OFF_W +: IDX_W];

  always_comb begin
    size_bytes = 4'd1;
    lane8      = 8'h01;
    case (size_mem)
      2'b00:   begin size_bytes = 4'd1; lane8 = 8'h01; end
      2'b01:   begin size_bytes = 4'd2; lane8 = 8'h03; end
      2'b10:   begin size_bytes = 4'd4; lane8 = 8'h0F; end
      default: begin size_bytes = 4'd8; lane8 = 8'hFF; end
    endcase
  end

  // A double access cannot be aligned on a 32-bit datapath.
  assign size_ok  = (DATA_W == 64) || (size_mem != 2'b11);
  assign aligned  = size_ok && ((4'(offset) & 4'(size_bytes - 4'd1)) == 4'd0);
  assign access   = valid_mem & (memread_mem | memwrite_mem);
  assign mem_op   = access & aligned;
  assign misalign = access & ~aligned;

  assign complete = mem_op & (LAT0 | ((state == BUSY) & (cnt == 4'd1)));
  assign stall    = mem_op & ~complete & ~reset;
  assign mem_we   = complete & memwrite_mem & ~reset;

  assign be          = NB'(lane8 << offset);
  assign wdata_shift = store_data_mem << {offset, 3'b000};

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata_shift[8*b +: 8];
      end
    end
  end

  assign rd_word   = mem[word_idx];
  assign rd_shift  = rd_word >> {offset, 3'b000};
  assign data_mask = ~({DATA_W{1'b1}} << {size_bytes, 3'b000});

  always_comb begin
    sign_bit = 1'b0;
    case (size_mem)
      2'b00:   sign_bit = rd_shift[7];
      2'b01:   sign_bit = rd_shift[15];
      2'b10:   sign_bit = rd_shift[31];
      default: sign_bit = rd_shift[DATA_W-1];
    endcase
  end

  assign load_ext       = (rd_shift & data_mask) | ({DATA_W{sign_mem & sign_bit}} & ~data_mask);
  assign read_data_next = (memread_mem & mem_op) ? load_ext : '0;

  // Latency FSM: IDLE accepts an access, BUSY counts down to the completing cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && !LAT0) begin
            state <= BUSY;
            cnt   <= 4'(MEM_LATENCY);
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign state_dbg = (state == BUSY);
  assign cnt_dbg   = cnt;

  // While stalled a bubble enters WB and the data fields keep their last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_wb     <= 1'b0;
      regwrite_wb  <= 1'b0;
      mem2reg_wb   <= 1'b0;
      misalign_wb  <= 1'b0;
      rd_wb        <= 5'd0;
      alu_out_wb   <= '0;
      read_data_wb <= '0;
    end else if (stall) begin
      valid_wb    <= 1'b0;
      regwrite_wb <= 1'b0;
      mem2reg_wb  <= 1'b0;
      misalign_wb <= 1'b0;
    end else begin
      valid_wb     <= valid_mem;
      regwrite_wb  <= valid_mem & regwrite_mem & ~misalign;
      mem2reg_wb   <= mem2reg_mem;
      misalign_wb  <= misalign;
      rd_wb        <= rd_mem;
      alu_out_wb   <= alu_out_mem;
      read_data_wb <= misalign ? '0 : read_data_next;
    end
  end

endmodule
